// File: rtl/neuron_feeder.sv
// neuron_feeder: serial-to-parallel front end for a single Neuron instance.
// It collects pixel/weight beats into the parallel buses and launches the neuron.
// It then waits for the neuron's response, or a watchdog timeout, and returns the
// result over a valid/ready port.
module neuron_feeder #(
    parameter int unsigned NUM_INPUTS = 64,
    parameter int unsigned PIX_W      = 10,
    parameter int unsigned WGT_W      = 19,
    parameter int unsigned OUT_W      = 26,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        GlobalReset_n,
    // Serial beat input
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [PIX_W-1:0]            s_pix,
    input  logic [WGT_W-1:0]            s_wgt,
    input  logic                        s_last,
    // Neuron side
    output logic [NUM_INPUTS*PIX_W-1:0] pix_bus,
    output logic [NUM_INPUTS*WGT_W-1:0] wgt_bus,
    output logic                        neuron_in_valid,
    input  logic [OUT_W-1:0]            neuron_out,
    input  logic                        neuron_out_valid,
    // Result port
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [OUT_W-1:0]            res_data,
    output logic                        res_error,
    output logic                        busy
);

    localparam int unsigned IDX_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned PBUS_W  = NUM_INPUTS * PIX_W;
    localparam int unsigned WBUS_W  = NUM_INPUTS * WGT_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               prev_valid_q;
    logic               in_valid_q;
    logic [OUT_W-1:0]   res_data_q;
    logic               res_error_q;
    logic [PBUS_W-1:0]  pix_q;
    logic [PBUS_W-1:0]  pix_d;
    logic [WBUS_W-1:0]  wgt_q;
    logic [WBUS_W-1:0]  wgt_d;

    logic               accept;
    logic               frame_end;
    logic               edge_seen;
    logic               timeout_hit;
    logic [CNT_W-1:0]   cnt_inc;

    // Handshake and event decode shared by the FSM and the bus writer
    assign accept      = (state_q == FILL) && s_valid;
    assign frame_end   = accept && (s_last || (idx_q == LAST_IDX));
    assign edge_seen   = (state_q == WAIT) && neuron_out_valid && !prev_valid_q;
    assign cnt_inc     = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = (state_q == WAIT) && (cnt_inc == TO_LIMIT);

    // Sequencer: frame fill, launch pulse, response wait with watchdog, result hold
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_q      <= FILL;
            idx_q        <= '0;
            cnt_q        <= '0;
            prev_valid_q <= 1'b0;
            in_valid_q   <= 1'b0;
            res_data_q   <= '0;
            res_error_q  <= 1'b0;
        end else begin
            in_valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (frame_end) begin
                            idx_q      <= '0;
                            in_valid_q <= 1'b1;
                            state_q    <= LAUNCH;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                LAUNCH: begin
                    cnt_q        <= '0;
                    prev_valid_q <= 1'b0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    prev_valid_q <= neuron_out_valid;
                    cnt_q        <= cnt_inc;
                    // A response edge takes priority over a simultaneous timeout
                    if (edge_seen) begin
                        res_data_q  <= neuron_out;
                        res_error_q <= 1'b0;
                        state_q     <= RESULT;
                    end else if (timeout_hit) begin
                        res_data_q  <= '0;
                        res_error_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        idx_q   <= '0;
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    // Bus next value: write the indexed entry; an early last beat zeroes the tail
    always_comb begin
        pix_d = pix_q;
        wgt_d = wgt_q;
        if (accept) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (IDX_W'(i) == idx_q) begin
                    pix_d[i*PIX_W +: PIX_W] = s_pix;
                    wgt_d[i*WGT_W +: WGT_W] = s_wgt;
                end else if (s_last && (IDX_W'(i) > idx_q)) begin
                    pix_d[i*PIX_W +: PIX_W] = '0;
                    wgt_d[i*WGT_W +: WGT_W] = '0;
                end
            end
        end
    end

    // Bus registers: only change on accepted beats, so they stay frozen outside FILL
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            pix_q <= '0;
            wgt_q <= '0;
        end else begin
            pix_q <= pix_d;
            wgt_q <= wgt_d;
        end
    end

    // Output mapping: handshake flags decode the state register directly
    assign s_ready         = (state_q == FILL);
    assign res_valid       = (state_q == RESULT);
    assign busy            = (state_q != FILL);
    assign neuron_in_valid = in_valid_q;
    assign res_data        = res_data_q;
    assign res_error       = res_error_q;
    assign pix_bus         = pix_q;
    assign wgt_bus         = wgt_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Self-checking bench for neuron_feeder: behavioural neuron model, bus model and result scoreboard.
`timescale 1ns/1ps
module tb_neuron_feeder;

    localparam int unsigned N  = 64;
    localparam int unsigned PW = 10;
    localparam int unsigned WW = 19;
    localparam int unsigned OW = 26;
    localparam int unsigned TO = 255;

    logic              clk = 1'b0;
    logic              GlobalReset_n = 1'b0;
    logic              s_valid;
    logic              s_ready;
    logic [PW-1:0]     s_pix;
    logic [WW-1:0]     s_wgt;
    logic              s_last;
    logic [N*PW-1:0]   pix_bus;
    logic [N*WW-1:0]   wgt_bus;
    logic              neuron_in_valid;
    logic [OW-1:0]     neuron_out;
    logic              neuron_out_valid;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_data;
    logic              res_error;
    logic              busy;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          err;
    } res_t;

    res_t sb[$];
    int   checks;
    int   errors;

    // Neuron model controls
    bit            model_en;
    int            model_lat;
    int            model_hold;
    logic [OW-1:0] model_out;
    logic          stray_ov;
    logic          m_ov;
    bit            m_pend;
    int            m_cnt;
    int            m_hold_cnt;

    // Bench bus model
    logic [PW-1:0] m_pix [N];
    logic [WW-1:0] m_wgt [N];
    int            m_idx;

    always #5 clk = ~clk;

    assign neuron_out_valid = m_ov | stray_ov;
    assign neuron_out       = model_out;

    neuron_feeder #(
        .NUM_INPUTS(N), .PIX_W(PW), .WGT_W(WW), .OUT_W(OW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .GlobalReset_n(GlobalReset_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_pix(s_pix),
        .s_wgt(s_wgt),
        .s_last(s_last),
        .pix_bus(pix_bus),
        .wgt_bus(wgt_bus),
        .neuron_in_valid(neuron_in_valid),
        .neuron_out(neuron_out),
        .neuron_out_valid(neuron_out_valid),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_error(res_error),
        .busy(busy)
    );

    // Neuron model: raises out_valid model_lat cycles after in_valid, for model_hold cycles
    always @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            m_pend     <= 1'b0;
            m_cnt      <= 0;
            m_ov       <= 1'b0;
            m_hold_cnt <= 0;
        end else begin
            if (m_ov) begin
                if (m_hold_cnt == 0) m_ov <= 1'b0;
                else m_hold_cnt <= m_hold_cnt - 1;
            end
            if (neuron_in_valid && model_en) begin
                m_pend <= 1'b1;
                m_cnt  <= 1;
            end else if (m_pend) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == model_lat - 1) begin
                    m_pend     <= 1'b0;
                    m_ov       <= 1'b1;
                    m_hold_cnt <= model_hold - 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*PW-1:0] model_pix_bus();
        logic [N*PW-1:0] v;
        for (int i = 0; i < N; i++) v[i*PW +: PW] = m_pix[i];
        return v;
    endfunction

    function automatic logic [N*WW-1:0] model_wgt_bus();
        logic [N*WW-1:0] v;
        for (int i = 0; i < N; i++) v[i*WW +: WW] = m_wgt[i];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_pix[i] = '0;
            m_wgt[i] = '0;
        end
        m_idx = 0;
    endtask

    // Drive one accepted beat and update the bench bus model
    task automatic send_beat(input logic [PW-1:0] p, input logic [WW-1:0] w, input logic last);
        s_valid = 1'b1;
        s_pix   = p;
        s_wgt   = w;
        s_last  = last;
        m_pix[m_idx] = p;
        m_wgt[m_idx] = w;
        if (last) begin
            for (int j = m_idx + 1; j < N; j++) begin
                m_pix[j] = '0;
                m_wgt[j] = '0;
            end
        end
        if (last || m_idx == N - 1) m_idx = 0;
        else m_idx = m_idx + 1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_pix   = '0;
        s_wgt   = '0;
    endtask

    task automatic wait_res(input int bound, output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_t dummy;
        s_valid = 1'b0; s_pix = '0; s_wgt = '0; s_last = 1'b0;
        res_ready = 1'b0; stray_ov = 1'b0;
        model_en = 1'b0; model_lat = 2; model_hold = 1; model_out = '0;
        clear_model();
        GlobalReset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pix_bus !== '0) begin errors++; $display("FAIL reset_pix: got %h exp 0", pix_bus); end
        checks++; if (wgt_bus !== '0) begin errors++; $display("FAIL reset_wgt: got %h exp 0", wgt_bus); end
        checks++; if (res_valid !== 1'b0 || res_error !== 1'b0 || res_data !== '0) begin
            errors++; $display("FAIL reset_res: valid %b err %b data %h exp 0 0 0", res_valid, res_error, res_data);
        end
        checks++; if (neuron_in_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: in_valid %b busy %b exp 0 0", neuron_in_valid, busy);
        end
        GlobalReset_n = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %b exp 1", s_ready); end
        dummy = '0;
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic test_full_frame();
        res_t e;
        int   c;
        model_en = 1'b1; model_lat = 62; model_hold = 1; model_out = 26'h0ABCDE;
        sb.push_back('{data: 26'h0ABCDE, err: 1'b0});
        for (int i = 0; i < N; i++) begin
            send_beat(PW'(i), 19'h01000 + WW'(i), 1'b0);
            if (i == N - 2) begin
                checks++; if (neuron_in_valid !== 1'b0) begin errors++; $display("FAIL full_early_launch: got %b exp 0", neuron_in_valid); end
            end
        end
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL full_launch: got %b exp 1", neuron_in_valid); end
        checks++; if (pix_bus[63*PW +: PW] !== 10'd63) begin errors++; $display("FAIL full_pix63: got %h exp %h", pix_bus[63*PW +: PW], 10'd63); end
        checks++; if (wgt_bus[63*WW +: WW] !== 19'h0103F) begin errors++; $display("FAIL full_wgt63: got %h exp %h", wgt_bus[63*WW +: WW], 19'h0103F); end
        checks++; if (pix_bus !== model_pix_bus()) begin errors++; $display("FAIL full_pix_bus: got %h exp %h", pix_bus, model_pix_bus()); end
        checks++; if (wgt_bus !== model_wgt_bus()) begin errors++; $display("FAIL full_wgt_bus: mismatch vs model, got %h", wgt_bus); end
        checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_launch_flags: s_ready %b busy %b exp 0 1", s_ready, busy); end
        tick();
        checks++; if (neuron_in_valid !== 1'b0) begin errors++; $display("FAIL full_pulse_width: got %b exp 0", neuron_in_valid); end
        wait_res(200, c);
        checks++; if (c + 1 != 63) begin errors++; $display("FAIL full_latency: got %0d exp 63", c + 1); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL full_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err) begin
                errors++; $display("FAIL full_result: data %h err %b exp %h %b", res_data, res_error, e.data, e.err);
            end
        end
        consume();
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_return: s_ready %b busy %b exp 1 0", s_ready, busy); end
    endtask

    task automatic test_early_end();
        res_t          e;
        int            c;
        logic [PW-1:0] ep;
        logic [WW-1:0] ew;
        model_en = 1'b1; model_lat = 5; model_hold = 1; model_out = 26'h1234567;
        sb.push_back('{data: 26'h1234567, err: 1'b0});
        for (int i = 0; i < 10; i++) begin
            send_beat(10'h3FF, 19'h7FFFF, (i == 9));
            if (i == 8) begin
                checks++; if (neuron_in_valid !== 1'b0) begin errors++; $display("FAIL early_premature_launch: got %b exp 0", neuron_in_valid); end
            end
        end
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL early_launch: got %b exp 1", neuron_in_valid); end
        for (int k = 0; k < N; k++) begin
            ep = (k < 10) ? 10'h3FF : 10'h000;
            ew = (k < 10) ? 19'h7FFFF : 19'h00000;
            checks++; if (pix_bus[k*PW +: PW] !== ep) begin errors++; $display("FAIL early_pix[%0d]: got %h exp %h", k, pix_bus[k*PW +: PW], ep); end
            checks++; if (wgt_bus[k*WW +: WW] !== ew) begin errors++; $display("FAIL early_wgt[%0d]: got %h exp %h", k, wgt_bus[k*WW +: WW], ew); end
        end
        wait_res(50, c);
        checks++; if (c != 6) begin errors++; $display("FAIL early_latency: got %0d exp 6", c); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL early_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err) begin
                errors++; $display("FAIL early_result: data %h err %b exp %h %b", res_data, res_error, e.data, e.err);
            end
        end
        consume();
    endtask

    task automatic test_timeout();
        res_t e;
        int   c;
        int   busy_bad;
        model_en = 1'b0;
        sb.push_back('{data: '0, err: 1'b1});
        send_beat(10'd1, 19'd7, 1'b0);
        send_beat(10'd2, 19'd8, 1'b0);
        send_beat(10'd3, 19'd9, 1'b1);
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL to_launch: got %b exp 1", neuron_in_valid); end
        c = 0;
        busy_bad = 0;
        while (res_valid !== 1'b1 && c < 300) begin
            tick();
            c++;
            if (busy !== 1'b1) busy_bad++;
        end
        checks++; if (c != TO + 1) begin errors++; $display("FAIL to_latency: got %0d exp %0d", c, TO + 1); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL to_busy: %0d cycles with busy low, exp 0", busy_bad); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL to_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err) begin
                errors++; $display("FAIL to_result: data %h err %b exp %h %b", res_data, res_error, e.data, e.err);
            end
        end
        repeat (3) tick();
        checks++; if (busy !== 1'b1 || res_valid !== 1'b1) begin errors++; $display("FAIL to_hold: busy %b valid %b exp 1 1", busy, res_valid); end
        consume();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_release: busy %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        res_t e;
        int   c;
        int   bad;
        model_en = 1'b1; model_lat = 10; model_hold = 2; model_out = 26'h3FFFFFF;
        sb.push_back('{data: 26'h3FFFFFF, err: 1'b0});
        e = '0;
        for (int i = 0; i < N; i++) begin
            send_beat(PW'(i * 3 + 1), WW'(i * 7 + 5), 1'b0);
            if (i < N - 1) begin
                s_pix = 10'h2AA;
                s_wgt = 19'h55555;
                tick();
            end
            if (i == 31) begin
                checks++; if (pix_bus !== model_pix_bus()) begin errors++; $display("FAIL bp_mid_pix: got %h exp %h", pix_bus, model_pix_bus()); end
            end
        end
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL bp_launch: got %b exp 1", neuron_in_valid); end
        checks++; if (pix_bus !== model_pix_bus()) begin errors++; $display("FAIL bp_pix: got %h exp %h", pix_bus, model_pix_bus()); end
        checks++; if (wgt_bus !== model_wgt_bus()) begin errors++; $display("FAIL bp_wgt: mismatch vs model, got %h", wgt_bus); end
        wait_res(50, c);
        checks++; if (c != 11) begin errors++; $display("FAIL bp_latency: got %0d exp 11", c); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err) begin
                errors++; $display("FAIL bp_result: data %h err %b exp %h %b", res_data, res_error, e.data, e.err);
            end
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (res_data !== e.data || res_valid !== 1'b1 || s_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, exp 0", bad); end
        consume();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_sready: got %b exp 1", s_ready); end
    endtask

    task automatic test_stray_valid();
        res_t e;
        int   c;
        int   bad;
        model_en = 1'b1; model_lat = 4; model_hold = 5; model_out = 26'h2468ACE;
        sb.push_back('{data: 26'h2468ACE, err: 1'b0});
        stray_ov = 1'b1;
        tick();
        tick();
        stray_ov = 1'b0;
        tick();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stray_fill: valid %b busy %b exp 0 0", res_valid, busy); end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) stray_ov = 1'b1;
            send_beat(PW'(i + 100), WW'(i + 200), (i == 7));
            stray_ov = 1'b0;
        end
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL stray_launch: got %b exp 1", neuron_in_valid); end
        wait_res(30, c);
        checks++; if (c != 5) begin errors++; $display("FAIL stray_latency: got %0d exp 5", c); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stray_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err) begin
                errors++; $display("FAIL stray_result: data %h err %b exp %h %b", res_data, res_error, e.data, e.err);
            end
        end
        consume();
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stray_second: %0d cycles with extra result, exp 0", bad); end
    endtask

    task automatic test_reset_mid_wait();
        res_t e;
        int   c;
        model_en = 1'b0;
        for (int i = 0; i < N; i++) send_beat(PW'(i) ^ 10'h155, WW'(i) ^ 19'h2A5A5, 1'b0);
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL rst_launch: got %b exp 1", neuron_in_valid); end
        repeat (30) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_prewait: busy %b exp 1", busy); end
        GlobalReset_n = 1'b0;
        #1;
        checks++; if (pix_bus !== '0 || wgt_bus !== '0) begin errors++; $display("FAIL rst_buses: pix %h exp 0", pix_bus); end
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || neuron_in_valid !== 1'b0) begin
            errors++; $display("FAIL rst_flags: valid %b busy %b in_valid %b exp 0 0 0", res_valid, busy, neuron_in_valid);
        end
        @(posedge clk);
        #1;
        GlobalReset_n = 1'b1;
        clear_model();
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_sready: got %b exp 1", s_ready); end
        model_en = 1'b1; model_lat = 62; model_hold = 1; model_out = 26'h15A5A5A;
        sb.push_back('{data: 26'h15A5A5A, err: 1'b0});
        for (int i = 0; i < N; i++) send_beat(PW'(i), WW'(i * 2), 1'b0);
        checks++; if (neuron_in_valid !== 1'b1) begin errors++; $display("FAIL rst_new_launch: got %b exp 1", neuron_in_valid); end
        checks++; if (pix_bus !== model_pix_bus()) begin errors++; $display("FAIL rst_new_pix: got %h exp %h", pix_bus, model_pix_bus()); end
        wait_res(200, c);
        checks++; if (c != 63) begin errors++; $display("FAIL rst_new_latency: got %0d exp 63", c); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rst_sb: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (res_data !== e.data || res_error !== e.err) begin
                errors++; $display("FAIL rst_new_result: data %h err %b exp %h %b", res_data, res_error, e.data, e.err);
            end
        end
        consume();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_new_return: got %b exp 1", s_ready); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d entries, exp 0", sb.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_frame();
        test_early_end();
        test_timeout();
        test_backpressure();
        test_stray_valid();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
